// File: rtl/spi_master_cfg_if.sv
// Bus bundle for spi_master_cfg: command/config handshake plus the SPI pad signals.
// The master modport is the SPI engine's view; slave is the host/pad side.
interface spi_master_cfg_if #(
    parameter int MAX_BYTES = 8,
    parameter int CS_NUM    = 4,
    parameter int DIV_W     = 8
);
    localparam int DATA_W = MAX_BYTES * 8;
    localparam int LEN_W  = $clog2(MAX_BYTES + 1);
    localparam int CS_W   = (CS_NUM > 1) ? $clog2(CS_NUM) : 1;

    logic              start;
    logic              cfg_cpol;
    logic              cfg_cpha;
    logic              cfg_lsb;
    logic [LEN_W-1:0]  cfg_len;
    logic [CS_W-1:0]   cfg_cs;
    logic [DIV_W-1:0]  cfg_div;
    logic [DATA_W-1:0] tx_data;
    logic              busy;
    logic              done;
    logic              rx_valid;
    logic              clr_rdy;
    logic [DATA_W-1:0] rx_data;
    logic              SPI_SCLK;
    logic              SPI_MOSI;
    logic              SPI_MISO;
    logic [CS_NUM-1:0] SPI_CS;

    modport master (
        input  start, cfg_cpol, cfg_cpha, cfg_lsb, cfg_len, cfg_cs, cfg_div,
        input  tx_data, clr_rdy, SPI_MISO,
        output busy, done, rx_valid, rx_data, SPI_SCLK, SPI_MOSI, SPI_CS
    );

    modport slave (
        output start, cfg_cpol, cfg_cpha, cfg_lsb, cfg_len, cfg_cs, cfg_div,
        output tx_data, clr_rdy, SPI_MISO,
        input  busy, done, rx_valid, rx_data, SPI_SCLK, SPI_MOSI, SPI_CS
    );
endinterface

// File: rtl/spi_master_cfg.sv
// Runtime-configurable SPI master: CPOL/CPHA modes, bit order, 1..MAX_BYTES per transfer,
// SCLK divider, CS select with lead/lag timing, full-duplex shift engine.
module spi_master_cfg #(
    parameter int MAX_BYTES = 8,
    parameter int CS_NUM    = 4,
    parameter int DIV_W     = 8,
    parameter int CS_LEAD   = 2,
    parameter int CS_LAG    = 2
) (
    input  logic           clk,
    input  logic           rst,
    spi_master_cfg_if.master bus
);
    localparam int DATA_W = MAX_BYTES * 8;
    localparam int LEN_W  = $clog2(MAX_BYTES + 1);
    localparam int CS_W   = (CS_NUM > 1) ? $clog2(CS_NUM) : 1;
    localparam int BIT_W  = $clog2(DATA_W + 1);
    localparam int EDGE_W = $clog2(2 * DATA_W + 1);
    localparam int PH_MAX = (CS_LEAD > CS_LAG) ? CS_LEAD : CS_LAG;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    typedef enum logic [1:0] {IDLE, LEAD, XFER, LAG} state_e;

    state_e            state_q;
    logic              cpol_q, cpha_q, lsb_q;
    logic [DIV_W-1:0]  div_q, halfCnt_q;
    logic [BIT_W-1:0]  nBits_q;
    logic [EDGE_W-1:0] edgeCnt_q;
    logic [PH_W-1:0]   phaseCnt_q;
    logic [DATA_W-1:0] txShift_q, rxShift_q, rxData_q;
    logic [CS_NUM-1:0] csN_q;
    logic              sclk_q, mosi_q, busy_q, done_q, rxValid_q;

    logic [LEN_W-1:0]  lenEff;
    logic [BIT_W-1:0]  nBitsIn;
    logic [DATA_W-1:0] txAligned;
    logic [CS_NUM-1:0] csSelN;
    logic              firstBit;
    logic [DATA_W-1:0] txShift_d, rxShift_d, rxFinal;
    logic              headBit_d;
    logic [EDGE_W-1:0] edgeNum, lastEdge;
    logic              halfEnd, sampleEdge, skipShift;

    // MSB-first words are pre-aligned so the next bit out is always the top bit.
    always_comb begin
        lenEff = bus.cfg_len;
        if (bus.cfg_len == '0) begin
            lenEff = LEN_W'(1);
        end else if (bus.cfg_len > LEN_W'(MAX_BYTES)) begin
            lenEff = LEN_W'(MAX_BYTES);
        end
        nBitsIn   = BIT_W'(lenEff) << 3;
        txAligned = bus.cfg_lsb ? bus.tx_data
                                : (bus.tx_data << (BIT_W'(DATA_W) - nBitsIn));
        firstBit  = bus.cfg_lsb ? bus.tx_data[0] : txAligned[DATA_W-1];
        csSelN    = '1;
        for (int i = 0; i < CS_NUM; i++) begin
            csSelN[i] = (bus.cfg_cs != CS_W'(i));
        end
    end

    always_comb begin
        txShift_d  = lsb_q ? (txShift_q >> 1) : (txShift_q << 1);
        headBit_d  = lsb_q ? txShift_d[0] : txShift_d[DATA_W-1];
        rxShift_d  = lsb_q ? {bus.SPI_MISO, rxShift_q[DATA_W-1:1]}
                           : {rxShift_q[DATA_W-2:0], bus.SPI_MISO};
        rxFinal    = lsb_q ? (rxShift_q >> (BIT_W'(DATA_W) - nBits_q)) : rxShift_q;
        halfEnd    = (halfCnt_q == div_q);
        edgeNum    = edgeCnt_q + EDGE_W'(1);
        lastEdge   = EDGE_W'(nBits_q) << 1;
        sampleEdge = edgeNum[0] ^ cpha_q;
        skipShift  = cpha_q ? (edgeNum == EDGE_W'(1)) : (edgeNum == lastEdge);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            lsb_q      <= 1'b0;
            div_q      <= '0;
            halfCnt_q  <= '0;
            nBits_q    <= '0;
            edgeCnt_q  <= '0;
            phaseCnt_q <= '0;
            txShift_q  <= '0;
            rxShift_q  <= '0;
            rxData_q   <= '0;
            csN_q      <= '1;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rxValid_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.clr_rdy) begin
                rxValid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    sclk_q <= bus.cfg_cpol;
                    mosi_q <= 1'b0;
                    if (bus.start) begin
                        cpol_q     <= bus.cfg_cpol;
                        cpha_q     <= bus.cfg_cpha;
                        lsb_q      <= bus.cfg_lsb;
                        div_q      <= bus.cfg_div;
                        nBits_q    <= nBitsIn;
                        txShift_q  <= txAligned;
                        rxShift_q  <= '0;
                        mosi_q     <= firstBit;
                        csN_q      <= csSelN;
                        busy_q     <= 1'b1;
                        rxValid_q  <= 1'b0;
                        phaseCnt_q <= '0;
                        state_q    <= LEAD;
                    end
                end
                LEAD: begin
                    if (phaseCnt_q == PH_W'(CS_LEAD - 1)) begin
                        halfCnt_q <= '0;
                        edgeCnt_q <= '0;
                        state_q   <= XFER;
                    end else begin
                        phaseCnt_q <= phaseCnt_q + PH_W'(1);
                    end
                end
                XFER: begin
                    if (halfEnd) begin
                        halfCnt_q <= '0;
                        edgeCnt_q <= edgeNum;
                        sclk_q    <= ~sclk_q;
                        // Sampling uses MISO as seen before the slave reacts to this edge.
                        if (sampleEdge) begin
                            rxShift_q <= rxShift_d;
                        end else if (!skipShift) begin
                            txShift_q <= txShift_d;
                            mosi_q    <= headBit_d;
                        end
                        if (edgeNum == lastEdge) begin
                            phaseCnt_q <= '0;
                            state_q    <= LAG;
                        end
                    end else begin
                        halfCnt_q <= halfCnt_q + DIV_W'(1);
                    end
                end
                LAG: begin
                    if (phaseCnt_q == PH_W'(CS_LAG - 1)) begin
                        csN_q     <= '1;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        rxData_q  <= rxFinal;
                        rxValid_q <= ~bus.clr_rdy;
                        state_q   <= IDLE;
                    end else begin
                        phaseCnt_q <= phaseCnt_q + PH_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.rx_valid = rxValid_q;
    assign bus.rx_data  = rxData_q;
    assign bus.SPI_SCLK = sclk_q;
    assign bus.SPI_MOSI = mosi_q;
    assign bus.SPI_CS   = csN_q;
endmodule

// File: tb/tb_spi_master_cfg.sv
// Self-checking bench for spi_master_cfg: vector table, corner-case sequences and
// randomized transfers against a bit-level SPI slave model.
module tb_spi_master_cfg;
    localparam int MAX_BYTES = 8;
    localparam int CS_NUM    = 4;
    localparam int DIV_W     = 8;
    localparam int CS_LEAD   = 2;
    localparam int CS_LAG    = 2;
    localparam int BUDGET    = 1000;
    localparam int NV        = 7;

    typedef struct {
        logic        cpol, cpha, lsb;
        logic [3:0]  len;
        logic [7:0]  div;
        logic [1:0]  cs;
        logic        loopback;
        logic [63:0] tx, slave, expRx;
        int          expLat;
    } vec_t;

    logic clk;
    logic rst;
    logic loopMode;
    logic slaveMiso;
    int   assertCount;
    int   failCount;
    vec_t vecs[NV];

    spi_master_cfg_if #(.MAX_BYTES(MAX_BYTES), .CS_NUM(CS_NUM), .DIV_W(DIV_W)) bus ();

    spi_master_cfg #(
        .MAX_BYTES(MAX_BYTES), .CS_NUM(CS_NUM), .DIV_W(DIV_W),
        .CS_LEAD(CS_LEAD), .CS_LAG(CS_LAG)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    assign bus.SPI_MISO = loopMode ? bus.SPI_MOSI : slaveMiso;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int effLen(input logic [3:0] len);
        if (len == 0) return 1;
        if (int'(len) > MAX_BYTES) return MAX_BYTES;
        return int'(len);
    endfunction

    function automatic int expLatency(input logic [3:0] len, input logic [7:0] div);
        return 1 + CS_LEAD + 2 * 8 * effLen(len) * (int'(div) + 1) + CS_LAG;
    endfunction

    function automatic logic [63:0] maskBits(input logic [63:0] w, input int n);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[i] = w[i];
        return r;
    endfunction

    // Bit p of the serial stream for a word sent in the given order.
    function automatic logic seqBit(input logic [63:0] w, input int p, input int n, input logic lsb);
        return lsb ? w[p] : w[n-1-p];
    endfunction

    function automatic vec_t mkVec(input logic cpol, input logic cpha, input logic lsb,
                                   input logic [3:0] len, input logic [7:0] div,
                                   input logic [1:0] cs, input logic loopback,
                                   input logic [63:0] tx, input logic [63:0] slave,
                                   input logic [63:0] expRx, input int expLat);
        vec_t v;
        v.cpol = cpol; v.cpha = cpha; v.lsb = lsb; v.len = len; v.div = div; v.cs = cs;
        v.loopback = loopback; v.tx = tx; v.slave = slave; v.expRx = expRx; v.expLat = expLat;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Runs one transfer while acting as the SPI slave and watching pad timing.
    task automatic applyStimulus(input vec_t v, input bit disturb, input bit clrAtDone);
        int          n, cycle, edges, csLow, p;
        logic [63:0] mosiWord;
        logic [3:0]  csExp;
        logic        prevSclk;
        bit          doneSeen, odd, sample;
        n = 8 * effLen(v.len);
        csExp = 4'hF;
        csExp[v.cs] = 1'b0;
        bus.cfg_cpol = v.cpol; bus.cfg_cpha = v.cpha; bus.cfg_lsb = v.lsb;
        bus.cfg_len = v.len; bus.cfg_div = v.div; bus.cfg_cs = v.cs; bus.tx_data = v.tx;
        loopMode = v.loopback;
        slaveMiso = seqBit(v.slave, 0, n, v.lsb);
        @(negedge clk);
        checkOutput("idleSclk", 64'(bus.SPI_SCLK), 64'(v.cpol));
        checkOutput("idleCs", 64'(bus.SPI_CS), 64'hF);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        checkOutput("startBusy", 64'(bus.busy), 64'd1);
        checkOutput("startClrValid", 64'(bus.rx_valid), 64'd0);
        checkOutput("startCs", 64'(bus.SPI_CS), 64'(csExp));
        cycle = 1; edges = 0; csLow = 0; mosiWord = '0; prevSclk = v.cpol; doneSeen = 0;
        while (cycle <= BUDGET) begin
            if (bus.done) begin
                doneSeen = 1;
                break;
            end
            if (bus.SPI_CS == csExp) csLow++;
            if (bus.SPI_SCLK != prevSclk) begin
                edges++;
                prevSclk = bus.SPI_SCLK;
                odd = (edges % 2) == 1;
                sample = v.cpha ? !odd : odd;
                if (sample) begin
                    p = (edges - 1) / 2;
                    if (p < n) mosiWord[v.lsb ? p : n - 1 - p] = bus.SPI_MOSI;
                end else begin
                    p = edges / 2;
                    if (p < n) slaveMiso = seqBit(v.slave, p, n, v.lsb);
                end
            end
            if (disturb && cycle == 10) begin
                bus.start = 1'b1;
                bus.cfg_cpol = ~v.cpol; bus.cfg_cpha = ~v.cpha; bus.cfg_lsb = ~v.lsb;
                bus.cfg_len = 4'd3; bus.cfg_div = 8'd5; bus.cfg_cs = v.cs + 2'd1;
                bus.tx_data = ~v.tx;
            end
            if (disturb && cycle == 11) bus.start = 1'b0;
            bus.clr_rdy = clrAtDone && (cycle == v.expLat - 1);
            @(negedge clk);
            cycle++;
        end
        bus.clr_rdy = 1'b0;
        checkOutput("doneSeen", 64'(doneSeen), 64'd1);
        checkOutput("latency", 64'(cycle), 64'(v.expLat));
        checkOutput("rxData", bus.rx_data, v.expRx);
        checkOutput("rxValid", 64'(bus.rx_valid), 64'(!clrAtDone));
        checkOutput("sclkEdges", 64'(edges), 64'(2 * n));
        checkOutput("mosiSeq", mosiWord, maskBits(v.tx, n));
        checkOutput("csLowCycles", 64'(csLow), 64'(v.expLat - 1));
        checkOutput("sclkRest", 64'(bus.SPI_SCLK), 64'(v.cpol));
        checkOutput("csRelease", 64'(bus.SPI_CS), 64'hF);
        checkOutput("busyEnd", 64'(bus.busy), 64'd0);
        @(negedge clk);
        checkOutput("donePulse", 64'(bus.done), 64'd0);
        checkOutput("noRestart", 64'(bus.busy), 64'd0);
    endtask

    initial begin
        vec_t rv;
        int   n;
        bit   doneSeen;
        assertCount = 0;
        failCount   = 0;
        rst = 1'b1;
        loopMode = 1'b1;
        slaveMiso = 1'b0;
        bus.start = 1'b0; bus.clr_rdy = 1'b0;
        bus.cfg_cpol = 1'b1; bus.cfg_cpha = 1'b0; bus.cfg_lsb = 1'b0;
        bus.cfg_len = 4'd1; bus.cfg_div = 8'd0; bus.cfg_cs = 2'd0; bus.tx_data = '0;

        vecs[0] = mkVec(0, 0, 0, 4'd1, 8'd1, 2'd0, 1, 64'hA5, 64'h0, 64'hA5, 37);
        vecs[1] = mkVec(1, 1, 1, 4'd2, 8'd2, 2'd1, 0, 64'h1234, 64'hBEEF, 64'hBEEF, 101);
        vecs[2] = mkVec(0, 1, 0, 4'd8, 8'd0, 2'd2, 1, {$urandom, $urandom}, 64'h0, 64'h0, 133);
        vecs[2].expRx = vecs[2].tx;
        vecs[3] = mkVec(1, 0, 0, 4'd8, 8'd0, 2'd3, 1, {$urandom, $urandom}, 64'h0, 64'h0, 133);
        vecs[3].expRx = vecs[3].tx;
        vecs[4] = mkVec(0, 0, 0, 4'd0, 8'd0, 2'd0, 1, 64'hFFFF_0000_1234_563C, 64'h0, 64'h3C, 21);
        vecs[5] = mkVec(0, 1, 0, 4'd9, 8'd0, 2'd1, 1, 64'h0123_4567_89AB_CDEF, 64'h0,
                        64'h0123_4567_89AB_CDEF, 133);
        vecs[6] = mkVec(1, 0, 1, 4'd3, 8'd3, 2'd2, 0, 64'h00AA55, 64'hDEAD_BEEF_CAFE_F00D,
                        64'hFE_F00D, 197);

        repeat (3) @(negedge clk);
        checkOutput("rstBusy", 64'(bus.busy), 64'd0);
        checkOutput("rstDone", 64'(bus.done), 64'd0);
        checkOutput("rstValid", 64'(bus.rx_valid), 64'd0);
        checkOutput("rstRxData", bus.rx_data, 64'd0);
        checkOutput("rstSclk", 64'(bus.SPI_SCLK), 64'd0);
        checkOutput("rstMosi", 64'(bus.SPI_MOSI), 64'd0);
        checkOutput("rstCs", 64'(bus.SPI_CS), 64'hF);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) applyStimulus(vecs[i], 1'b0, 1'b0);

        // rx_valid is sticky until cleared
        @(negedge clk);
        checkOutput("validSticky", 64'(bus.rx_valid), 64'd1);
        bus.clr_rdy = 1'b1;
        @(negedge clk);
        bus.clr_rdy = 1'b0;
        checkOutput("clrRdy", 64'(bus.rx_valid), 64'd0);
        checkOutput("rxHeld", bus.rx_data, vecs[NV-1].expRx);

        applyStimulus(vecs[0], 1'b1, 1'b0);
        applyStimulus(vecs[4], 1'b0, 1'b1);

        // reset in the middle of XFER aborts with no done
        rv = vecs[1];
        bus.cfg_cpol = rv.cpol; bus.cfg_cpha = rv.cpha; bus.cfg_lsb = rv.lsb;
        bus.cfg_len = rv.len; bus.cfg_div = rv.div; bus.cfg_cs = rv.cs; bus.tx_data = rv.tx;
        loopMode = 1'b1;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("preRstBusy", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abortCs", 64'(bus.SPI_CS), 64'hF);
        checkOutput("abortSclk", 64'(bus.SPI_SCLK), 64'd0);
        checkOutput("abortBusy", 64'(bus.busy), 64'd0);
        checkOutput("abortValid", 64'(bus.rx_valid), 64'd0);
        doneSeen = 0;
        for (int c = 0; c < 150; c++) begin
            if (bus.done) doneSeen = 1;
            @(negedge clk);
        end
        checkOutput("abortNoDone", 64'(doneSeen), 64'd0);
        applyStimulus(vecs[1], 1'b0, 1'b0);

        for (int k = 0; k < 6; k++) begin
            rv.cpol = 1'($urandom_range(0, 1));
            rv.cpha = 1'($urandom_range(0, 1));
            rv.lsb = 1'($urandom_range(0, 1));
            rv.len = 4'($urandom_range(0, 9));
            rv.div = 8'($urandom_range(0, 3));
            rv.cs = 2'($urandom_range(0, 3));
            rv.loopback = 1'($urandom_range(0, 1));
            rv.tx = {$urandom, $urandom};
            rv.slave = {$urandom, $urandom};
            n = 8 * effLen(rv.len);
            rv.expRx = rv.loopback ? maskBits(rv.tx, n) : maskBits(rv.slave, n);
            rv.expLat = expLatency(rv.len, rv.div);
            applyStimulus(rv, 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
